// File: rtl/chrono_pkg.sv
// Shared types and helpers for the lap chronometer.
// Contents: FSM state enum, unit frequency constants, and chrono_div(), which turns an
// input clock frequency and a units selector into the prescaler divide ratio.
package chrono_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int UNIT_FREQ_MS = 1000;
  localparam int UNIT_FREQ_US = 1000000;

  // Clock cycles per elapsed unit; 0 means the clock is too slow for the chosen unit.
  function automatic int chrono_div(input int freq, input int units);
    return freq / ((units != 0) ? UNIT_FREQ_US : UNIT_FREQ_MS);
  endfunction

endpackage

// File: rtl/chrono_lap_fifo.sv
// Lap FIFO: pointer+count circular buffer with first-word fall-through head.
// Latency: a push into an empty FIFO appears on head_dat_o/vld_o one edge later; a pop advances the head on the next edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
// Ports: clk_i, rst_i (async, active high), clr_i (sync flush), push_i/push_dat_i, pop_i,
//        head_dat_o (zero when empty), vld_o, full_o, count_o.
module chrono_lap_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     vld_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("chrono_lap_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign vld_o   = (count_q != '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign rd_en = pop_i && vld_o && !clr_i;
  assign wr_en = push_i && (!full_o || rd_en) && !clr_i;

  // Masked so the head reads zero out of reset and when drained.
  assign head_dat_o = vld_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/lap_chronometer.sv
// Lap chronometer: prescaled elapsed-time counter with start/stop/clear FSM and lap capture.
// Latency: running follows start by one edge; first count DIV cycles after the start edge; laps visible one edge after capture.
// Backpressure: reader drains laps via lapReadEn; new laps are dropped while the store is full.
// Ports: clk, resetChronometer (async, active high), start/stop/clear/lap/lapReadEn controls;
//        recordTimer, running, overflow, lapData, lapValid, lapFull, lapCount status.
// Build option: define CHRONO_LAP_FIFO_EN for a LAP_DEPTH-entry lap FIFO; otherwise a single lap register is used.
module lap_chronometer #(
  parameter int FREQ_IN      = 10000,
  parameter int SELECT_UNITS = 0,
  parameter int TIMER_WIDTH  = 16,
  parameter int LAP_DEPTH    = 4,
  parameter int SATURATE     = 0
) (
  input  logic                         clk,
  input  logic                         resetChronometer,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic                         lap,
  input  logic                         lapReadEn,
  output logic [TIMER_WIDTH-1:0]       recordTimer,
  output logic                         running,
  output logic                         overflow,
  output logic [TIMER_WIDTH-1:0]       lapData,
  output logic                         lapValid,
  output logic                         lapFull,
  output logic [$clog2(LAP_DEPTH):0]   lapCount
);

  import chrono_pkg::*;

  localparam int DIV = chrono_div(FREQ_IN, SELECT_UNITS);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(LAP_DEPTH) + 1;
  localparam logic [TIMER_WIDTH-1:0] TMAX = '1;

  if (DIV < 1) begin : g_bad_div
    $error("lap_chronometer: FREQ_IN too low for the selected unit");
  end

  state_t                 state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   ovf_q, ovf_d;
  logic                   tick;
  logic                   lap_push;

  assign running     = (state_q == RUN);
  assign recordTimer = timer_q;
  assign overflow    = ovf_q;
  assign tick        = running && (presc_q == PW'(DIV - 1));

  // Priority clear > stop > start; a stop always masks a coincident start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if (state_q != RUN) state_d = RUN;
    end
  end

  // Prescaler only moves in RUN, so its residue survives a pause.
  always_comb begin
    presc_d = presc_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    if (clear) begin
      presc_d = '0;
      timer_d = '0;
      ovf_d   = 1'b0;
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (timer_q == TMAX) begin
          ovf_d   = 1'b1;
          timer_d = (SATURATE != 0) ? TMAX : '0;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetChronometer) begin
    if (resetChronometer) begin
      state_q <= IDLE;
      presc_q <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
    end
  end

  // Captures the pre-edge time; laps in IDLE or alongside clear are discarded.
  assign lap_push = lap && !clear && (state_q != IDLE);

`ifdef CHRONO_LAP_FIFO_EN
  chrono_lap_fifo #(
    .WIDTH (TIMER_WIDTH),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk_i      (clk),
    .rst_i      (resetChronometer),
    .clr_i      (clear),
    .push_i     (lap_push),
    .push_dat_i (timer_q),
    .pop_i      (lapReadEn),
    .head_dat_o (lapData),
    .vld_o      (lapValid),
    .full_o     (lapFull),
    .count_o    (lapCount)
  );
`else
  logic [TIMER_WIDTH-1:0] lap_q;
  logic                   lap_vld_q;

  // A new lap wins over a coincident read; the data stays visible after the read.
  always_ff @(posedge clk or posedge resetChronometer) begin
    if (resetChronometer) begin
      lap_q     <= '0;
      lap_vld_q <= 1'b0;
    end else if (clear) begin
      lap_q     <= '0;
      lap_vld_q <= 1'b0;
    end else if (lap_push) begin
      lap_q     <= timer_q;
      lap_vld_q <= 1'b1;
    end else if (lapReadEn) begin
      lap_vld_q <= 1'b0;
    end
  end

  assign lapData  = lap_q;
  assign lapValid = lap_vld_q;
  assign lapFull  = 1'b0;
  assign lapCount = CW'(lap_vld_q);
`endif

endmodule

// File: tb/tb_lap_chronometer.sv
module tb_lap_chronometer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0, lapReadEn = 1'b0;

  // Main instance: 16-bit timer, ms units at 10 kHz (DIV = 10).
  logic [15:0] timer, lap_dat;
  logic        run, ovf, lap_vld, lap_full;
  logic [2:0]  lap_cnt;

  // 4-bit instances for wrap and saturate overflow.
  logic [3:0]  w_timer, w_lap_dat, s_timer, s_lap_dat;
  logic        w_run, w_ovf, w_vld, w_full, s_run, s_ovf, s_vld, s_full;
  logic [2:0]  w_cnt, s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lap_chronometer #(.FREQ_IN(10000), .SELECT_UNITS(0), .TIMER_WIDTH(16), .LAP_DEPTH(4), .SATURATE(0)) u_dut (
    .clk(clk), .resetChronometer(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .lapReadEn(lapReadEn), .recordTimer(timer), .running(run), .overflow(ovf), .lapData(lap_dat),
    .lapValid(lap_vld), .lapFull(lap_full), .lapCount(lap_cnt));

  lap_chronometer #(.FREQ_IN(10000), .SELECT_UNITS(0), .TIMER_WIDTH(4), .LAP_DEPTH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .resetChronometer(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .lapReadEn(lapReadEn), .recordTimer(w_timer), .running(w_run), .overflow(w_ovf), .lapData(w_lap_dat),
    .lapValid(w_vld), .lapFull(w_full), .lapCount(w_cnt));

  lap_chronometer #(.FREQ_IN(10000), .SELECT_UNITS(0), .TIMER_WIDTH(4), .LAP_DEPTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .resetChronometer(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .lapReadEn(lapReadEn), .recordTimer(s_timer), .running(s_run), .overflow(s_ovf), .lapData(s_lap_dat),
    .lapValid(s_vld), .lapFull(s_full), .lapCount(s_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge, return on the following negedge.
  task automatic step(input logic st, input logic sp, input logic cl, input logic lp, input logic rd);
    start = st; stop = sp; clear = cl; lap = lp; lapReadEn = rd;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; lapReadEn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic        st, sp, cl, lp, rd;
    logic        exp_run;
    logic        exp_vld;
    logic [15:0] exp_dat;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Control sequence from IDLE; timer stays 0 because fewer than DIV running cycles elapse.
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0}; // start+stop in IDLE: stop wins, stays IDLE
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0}; // stop in IDLE ignored
    vecs[2]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0}; // IDLE -> RUN
    vecs[3]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0}; // start in RUN ignored
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0}; // start+stop in RUN -> PAUSE
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0}; // PAUSE -> RUN
    vecs[6]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0}; // clear beats start
    vecs[7]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0}; // lap in IDLE ignored
    vecs[8]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0}; // IDLE -> RUN
    vecs[9]  = '{0, 0, 0, 1, 0, 1, 1, 0, 1}; // lap in RUN captures 0
    vecs[10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0}; // read empties the store
    vecs[11] = '{0, 0, 1, 1, 0, 0, 0, 0, 0}; // lap+clear discarded

    // Reset state, checked while reset is held.
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_timer", timer, 0);
    chk("rst_running", run, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_lapData", lap_dat, 0);
    chk("rst_lapValid", lap_vld, 0);
    chk("rst_lapFull", lap_full, 0);
    chk("rst_lapCount", lap_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven control and lap vectors.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].lp, vecs[i].rd);
      chk($sformatf("vec%0d_running", i), run, vecs[i].exp_run);
      chk($sformatf("vec%0d_lapValid", i), lap_vld, vecs[i].exp_vld);
      chk($sformatf("vec%0d_lapData", i), lap_dat, vecs[i].exp_dat);
      chk($sformatf("vec%0d_lapCount", i), lap_cnt, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_lapFull", i), lap_full, 0);
      chk($sformatf("vec%0d_timer", i), timer, 0);
    end

    // Count: first increment exactly DIV cycles after the start edge, 10 after 100.
    step(1, 0, 0, 0, 0);
    chk("cnt_running", run, 1);
    idle(9);
    chk("cnt_before_div", timer, 0);
    idle(1);
    chk("cnt_at_div", timer, 1);
    idle(90);
    chk("cnt_100", timer, 10);
    chk("cnt_100_running", run, 1);
    step(0, 0, 1, 0, 0);
    chk("clr_timer", timer, 0);
    chk("clr_running", run, 0);

    // Pause/resume keeps the prescaler residue (5 of 10 used before the pause).
    step(1, 0, 0, 0, 0);
    idle(24);
    step(0, 1, 0, 0, 0);
    chk("pause_timer", timer, 2);
    chk("pause_running", run, 0);
    idle(20);
    chk("pause_hold", timer, 2);
    step(1, 0, 0, 0, 0);
    chk("resume_running", run, 1);
    idle(4);
    chk("resume_not_yet", timer, 2);
    idle(1);
    chk("resume_residue", timer, 3);
    step(0, 0, 1, 0, 0);

    // Overflow on 4-bit timers: wrap vs saturate.
    step(1, 0, 0, 0, 0);
    idle(150);
    chk("ovf150_wrap_timer", w_timer, 15);
    chk("ovf150_wrap_flag", w_ovf, 0);
    chk("ovf150_sat_flag", s_ovf, 0);
    idle(10);
    chk("ovf160_wrap_timer", w_timer, 0);
    chk("ovf160_wrap_flag", w_ovf, 1);
    chk("ovf160_sat_timer", s_timer, 15);
    chk("ovf160_sat_flag", s_ovf, 1);
    idle(10);
    chk("ovf170_wrap_timer", w_timer, 1);
    chk("ovf170_wrap_flag", w_ovf, 1);
    chk("ovf170_sat_timer", s_timer, 15);
    chk("ovf170_sat_flag", s_ovf, 1);
    chk("ovf170_main_timer", timer, 17);
    chk("ovf170_main_flag", ovf, 0);
    step(0, 0, 1, 0, 0);
    chk("ovf_clear_wrap", w_ovf, 0);
    chk("ovf_clear_sat", s_ovf, 0);

`ifdef CHRONO_LAP_FIFO_EN
    // Five laps at timer 1..5 into a 4-deep FIFO; the fifth is dropped.
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      idle((k == 1) ? 10 : 9);
      step(0, 0, 0, 1, 0);
    end
    chk("fifo_full", lap_full, 1);
    chk("fifo_count", lap_cnt, 4);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fifo_pop%0d", k), lap_dat, k);
      step(0, 0, 0, 0, 1);
    end
    chk("fifo_drained_valid", lap_vld, 0);
    chk("fifo_drained_count", lap_cnt, 0);
    step(0, 0, 0, 0, 1);
    chk("fifo_pop_empty", lap_cnt, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
    chk("fifo_refill_full", lap_full, 1);
    step(0, 0, 0, 1, 1);
    chk("fifo_pushpop_count", lap_cnt, 4);
    chk("fifo_pushpop_full", lap_full, 1);
    step(0, 0, 0, 1, 0);
`else
    // Single lap register: second lap overwrites, read clears valid but keeps data.
    step(1, 0, 0, 0, 0);
    idle(10);
    step(0, 0, 0, 1, 0);
    chk("reg_lap1_data", lap_dat, 1);
    chk("reg_lap1_valid", lap_vld, 1);
    chk("reg_lap1_count", lap_cnt, 1);
    idle(9);
    step(0, 0, 0, 1, 0);
    chk("reg_lap2_data", lap_dat, 2);
    step(0, 0, 0, 0, 1);
    chk("reg_read_valid", lap_vld, 0);
    chk("reg_read_data", lap_dat, 2);
    chk("reg_read_count", lap_cnt, 0);
    chk("reg_full_tied", lap_full, 0);
    step(0, 0, 0, 1, 0);
`endif

    // Mid-run asynchronous reset between edges.
    idle(30);
    chk("prerst_running", run, 1);
    chk("prerst_lapValid", lap_vld, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_timer", timer, 0);
    chk("async_running", run, 0);
    chk("async_overflow", ovf, 0);
    chk("async_lapData", lap_dat, 0);
    chk("async_lapValid", lap_vld, 0);
    chk("async_lapCount", lap_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk("post_rst_idle_timer", timer, 0);
    chk("post_rst_idle_running", run, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
